branch_predict_resolve: RTL and testbench

//  Parametrised ID-stage branch unit with a direct-mapped branch target buffer (BTB).
//  - IF side: looks up the BTB with if_pc; supplies a predicted direction and target.
//  - ID side: resolves the branch, checks the carried prediction, raises a redirect on mispredict, trains the BTB.
//  - Replaces pure resolution with predict-and-verify. Sits between the IF PC mux and the ID decode/regfile read.

---
 rtl/branch_predict_resolve.sv | 165 ++++++++++++++++
 tb/tb_branch_predict_resolve.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve.sv
// ID-stage branch resolve unit with a direct-mapped BTB and 2-bit counters for IF prediction.
// Define BRANCH_STATS_EN to add the stat_branches / stat_mispredicts counters.
module branch_predict_resolve #(
    parameter int          IDX_W    = 6,
    parameter int          TAG_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic [31:0] id_pc,
    input  logic        id_pred_taken,
    input  logic [31:0] id_pred_target,
    input  logic [2:0]  id_branch,
    input  logic [31:0] id_branch_address,
    input  logic [31:0] id_jump_address,
    input  logic        inst_eret,
    input  logic        exception_happen,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [1:0]  PCSrc,
    output logic [31:0] redirect_target,
    output logic        branch_flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BGEZ = 3'b011,
        BR_BGTZ = 3'b100,
        BR_BLEZ = 3'b101,
        BR_BLTZ = 3'b110,
        BR_JUMP = 3'b111
    } br_e;

    typedef enum logic [1:0] {
        PC_SEQ   = 2'd0,
        PC_REDIR = 2'd1,
        PC_ERET  = 2'd2,
        PC_EXC   = 2'd3
    } pcsrc_e;

    logic              r_valid  [DEPTH];
    logic [1:0]        r_cnt    [DEPTH];
    logic [TAG_W-1:0]  r_tag    [DEPTH];
    logic [31:0]       r_target [DEPTH];

    logic [IDX_W-1:0]  w_if_idx, w_id_idx;
    logic [TAG_W-1:0]  w_if_tag, w_id_tag;
    logic              w_if_hit, w_id_hit, w_pred_taken;
    logic              w_act, w_train, w_taken, w_mispredict, w_is_jump;
    logic [31:0]       w_tgt;
    pcsrc_e            w_pcsrc;
    br_e               w_br;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_id_idx = id_pc[IDX_W+1:2];
    assign w_id_tag = id_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads the stored array only: a same-cycle training write is seen next cycle.
    assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_pred_taken = w_if_hit && r_cnt[w_if_idx][1];
    assign w_id_hit     = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);

    assign w_br      = br_e'(id_branch);
    assign w_is_jump = (w_br == BR_JUMP);
    assign w_act     = id_valid && !id_stall && (w_br != BR_NONE);
    assign w_train   = w_act && !exception_happen;
    assign w_tgt     = w_is_jump ? id_jump_address : id_branch_address;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_taken = 1'b0;
        case (w_br)
            BR_BEQ:  w_taken = (rs_val == rt_val);
            BR_BNE:  w_taken = (rs_val != rt_val);
            BR_BGEZ: w_taken = !rs_val[31];
            BR_BGTZ: w_taken = !rs_val[31] && (|rs_val);
            BR_BLEZ: w_taken = !(!rs_val[31] && (|rs_val));
            BR_BLTZ: w_taken = rs_val[31];
            BR_JUMP: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    assign w_mispredict = w_act && ((w_taken != id_pred_taken) ||
                                    (w_taken && (id_pred_target != w_tgt)));

    always_comb begin
        w_pcsrc = PC_SEQ;
        if (exception_happen)  w_pcsrc = PC_EXC;
        else if (inst_eret)    w_pcsrc = PC_ERET;
        else if (w_mispredict) w_pcsrc = PC_REDIR;
    end

    // All outputs are forced low while reset is held, including the purely combinational ones.
    assign if_pred_taken   = resetn && w_pred_taken;
    assign if_pred_target  = (resetn && w_pred_taken) ? r_target[w_if_idx] : 32'd0;
    assign PCSrc           = resetn ? w_pcsrc : PC_SEQ;
    assign branch_flush    = resetn && (w_pcsrc == PC_REDIR);
    assign redirect_target = !resetn ? 32'd0 : (w_taken ? w_tgt : 32'(id_pc + 32'd8));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the whole table is reset because a stale valid bit would give a false first prediction.
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_cnt[i]    <= CNT_INIT;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
            end
        end else if (w_train) begin
            if (w_id_hit) begin
                if (w_is_jump)
                    r_cnt[w_id_idx] <= 2'b11;
                else if (w_taken)
                    r_cnt[w_id_idx] <= (r_cnt[w_id_idx] == 2'b11) ? 2'b11 : r_cnt[w_id_idx] + 2'd1;
                else
                    r_cnt[w_id_idx] <= (r_cnt[w_id_idx] == 2'b00) ? 2'b00 : r_cnt[w_id_idx] - 2'd1;
                if (w_taken)
                    r_target[w_id_idx] <= w_tgt;
            end else if (w_taken) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= w_tgt;
                r_cnt[w_id_idx]    <= w_is_jump ? 2'b11 : CNT_INIT;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_branches, r_stat_mispredicts;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else if (w_train) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (w_mispredict)
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

    logic w_unused;
    assign w_unused = &{1'b0, if_pc[1:0], if_pc[31:IDX_W+TAG_W+2]};

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench: the driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        id_valid, id_stall, id_pred_taken, inst_eret, exception_happen;
    logic [31:0] id_pc, id_pred_target, id_branch_address, id_jump_address, rs_val, rt_val;
    logic [2:0]  id_branch;
    logic [1:0]  PCSrc;
    logic [31:0] redirect_target;
    logic        branch_flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    localparam logic [2:0] NONE = 3'd0, BEQ = 3'd1, BNE = 3'd2, BGEZ = 3'd3,
                           BGTZ = 3'd4, BLEZ = 3'd5, BLTZ = 3'd6, JUMP = 3'd7;

    always #5 clk = ~clk;

    branch_predict_resolve dut (
        .clk               (clk),
        .resetn            (resetn),
        .if_pc             (if_pc),
        .if_pred_taken     (if_pred_taken),
        .if_pred_target    (if_pred_target),
        .id_valid          (id_valid),
        .id_stall          (id_stall),
        .id_pc             (id_pc),
        .id_pred_taken     (id_pred_taken),
        .id_pred_target    (id_pred_target),
        .id_branch         (id_branch),
        .id_branch_address (id_branch_address),
        .id_jump_address   (id_jump_address),
        .inst_eret         (inst_eret),
        .exception_happen  (exception_happen),
        .rs_val            (rs_val),
        .rt_val            (rt_val),
        .PCSrc             (PCSrc),
        .redirect_target   (redirect_target),
        .branch_flush      (branch_flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] ptgt;
        logic [1:0]  pcsrc;
        logic        chk_rt;
        logic [31:0] rt;
        logic        chk_st;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic expect_o(input string nm, input logic pt, input logic [31:0] ptgt,
                            input logic [1:0] pcsrc, input logic chk_rt, input logic [31:0] rt,
                            input logic chk_st = 1'b0, input logic [31:0] sb = 0,
                            input logic [31:0] sm = 0);
        exp_t e;
        e.name = nm; e.pt = pt; e.ptgt = ptgt; e.pcsrc = pcsrc; e.chk_rt = chk_rt;
        e.rt = rt; e.chk_st = chk_st; e.sb = sb; e.sm = sm;
        q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".pred_taken"},  {31'd0, if_pred_taken}, {31'd0, e.pt});
                check({e.name, ".pred_target"}, if_pred_target, e.ptgt);
                check({e.name, ".PCSrc"},       {30'd0, PCSrc}, {30'd0, e.pcsrc});
                check({e.name, ".flush"},       {31'd0, branch_flush}, {31'd0, e.pcsrc == 2'd1});
                if (e.chk_rt)
                    check({e.name, ".redirect"}, redirect_target, e.rt);
`ifdef BRANCH_STATS_EN
                if (e.chk_st) begin
                    check({e.name, ".stat_br"}, stat_branches, e.sb);
                    check({e.name, ".stat_mp"}, stat_mispredicts, e.sm);
                end
`endif
            end
        end
    end

    // Drives one cycle just after the rising edge; side-band controls default low.
    task automatic issue(input logic [31:0] ifpc, input logic [2:0] kind, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt, input logic pt,
                         input logic [31:0] ptgt, input logic [31:0] baddr, input logic [31:0] jaddr);
        @(posedge clk);
        #1;
        if_pc = ifpc; id_branch = kind; id_valid = (kind != NONE); id_pc = pc;
        rs_val = rs; rt_val = rt; id_pred_taken = pt; id_pred_target = ptgt;
        id_branch_address = baddr; id_jump_address = jaddr;
        id_stall = 1'b0; inst_eret = 1'b0; exception_happen = 1'b0;
    endtask

    task automatic idle(input logic [31:0] ifpc);
        issue(ifpc, NONE, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        taken;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs = '{'{BNE, 5, 6, 1}, '{BNE, 5, 5, 0},
                 '{BGEZ, 0, 0, 1}, '{BGEZ, 32'h8000_0000, 0, 0},
                 '{BGTZ, 0, 0, 0}, '{BGTZ, 1, 0, 1}, '{BGTZ, 32'hFFFF_FFFF, 0, 0},
                 '{BLEZ, 0, 0, 1}, '{BLEZ, 1, 0, 0}, '{BLEZ, 32'h8000_0000, 0, 1},
                 '{BLTZ, 32'hFFFF_FFFF, 0, 1}, '{BLTZ, 32'h7FFF_FFFF, 0, 0}};

        // Reset held with noisy inputs: every output must still read zero.
        resetn = 1'b0; if_pc = 32'h1000; id_valid = 1'b1; id_stall = 1'b0; id_pc = 32'h1000;
        id_pred_taken = 1'b0; id_pred_target = 0; id_branch = BEQ; id_branch_address = 32'h1040;
        id_jump_address = 0; inst_eret = 1'b1; exception_happen = 1'b1; rs_val = 5; rt_val = 5;
        @(posedge clk); #1;
        expect_o("reset", 0, 0, 0, 1, 0, 1, 0, 0);
        @(negedge clk); #1;
        resetn = 1'b1;

        idle(32'h1000);                 expect_o("idle0", 0, 0, 0, 0, 0);
        issue(32'h1000, BEQ, 32'h1000, 5, 5, 0, 0, 32'h1040, 0);
        expect_o("beq_alloc", 0, 0, 1, 1, 32'h1040);
        idle(32'h1000);                 expect_o("lookup_alloc", 1, 32'h1040, 0, 0, 0);
        issue(32'h1000, BEQ, 32'h1000, 5, 6, 1, 32'h1040, 32'h1040, 0);
        expect_o("beq_nt", 1, 32'h1040, 1, 1, 32'h1008);
        idle(32'h1000);                 expect_o("lookup_01", 0, 0, 0, 0, 0);

        // Four taken: 01 -> 10 -> 11 -> 11 -> 11.
        issue(32'h1000, BEQ, 32'h1000, 5, 5, 0, 0, 32'h1040, 0);
        expect_o("tk1", 0, 0, 1, 1, 32'h1040);
        for (int i = 0; i < 3; i++) begin
            issue(32'h1000, BEQ, 32'h1000, 5, 5, 1, 32'h1040, 32'h1040, 0);
            expect_o($sformatf("tk%0d", i + 2), 1, 32'h1040, 0, 1, 32'h1040);
        end
        idle(32'h1000);                 expect_o("sat_hi", 1, 32'h1040, 0, 0, 0);

        // Four not taken: 11 -> 10 -> 01 -> 00 -> 00.
        for (int i = 0; i < 2; i++) begin
            issue(32'h1000, BEQ, 32'h1000, 5, 6, 1, 32'h1040, 32'h1040, 0);
            expect_o($sformatf("nt%0d", i + 1), 1, 32'h1040, 1, 1, 32'h1008);
        end
        for (int i = 0; i < 2; i++) begin
            issue(32'h1000, BEQ, 32'h1000, 5, 6, 0, 0, 32'h1040, 0);
            expect_o($sformatf("nt%0d", i + 3), 0, 0, 0, 1, 32'h1008);
        end
        idle(32'h1000);                 expect_o("sat_lo", 0, 0, 0, 0, 0);

        // Exception outranks a mispredict and blocks training of 0x2000.
        issue(32'h2000, BEQ, 32'h2000, 5, 5, 0, 0, 32'h2080, 0);
        exception_happen = 1'b1;        expect_o("exc", 0, 0, 3, 0, 0);
        idle(32'h2000);                 expect_o("exc_notrain", 0, 0, 0, 0, 0);
        idle(32'h2000);
        inst_eret = 1'b1;               expect_o("eret", 0, 0, 2, 0, 0);
        issue(32'h2000, BEQ, 32'h2000, 5, 5, 0, 0, 32'h2080, 0);
        inst_eret = 1'b1;               expect_o("eret_pri", 0, 0, 2, 1, 32'h2080);
        idle(32'h2000);                 expect_o("eret_train", 1, 32'h2080, 0, 0, 0);
        idle(32'h1000);                 expect_o("victim", 0, 0, 0, 0, 0);

        // Stall: no redirect, no training; re-evaluated on release.
        issue(32'h3000, BEQ, 32'h3000, 5, 5, 0, 0, 32'h3040, 0);
        id_stall = 1'b1;                expect_o("stall", 0, 0, 0, 0, 0);
        idle(32'h3000);                 expect_o("stall_notrain", 0, 0, 0, 0, 0);
        idle(32'h2000);                 expect_o("stall_keep", 1, 32'h2080, 0, 0, 0);
        issue(32'h3000, BEQ, 32'h3000, 5, 5, 0, 0, 32'h3040, 0);
        expect_o("stall_rel", 0, 0, 1, 1, 32'h3040);
        idle(32'h3000);                 expect_o("stall_train", 1, 32'h3040, 0, 0, 0);

        // Jump allocates at 11, so one not-taken still leaves it predicted taken.
        issue(32'h1104, JUMP, 32'h1104, 0, 0, 0, 0, 32'h5555, 32'h4000);
        expect_o("jump", 0, 0, 1, 1, 32'h4000);
        idle(32'h1104);                 expect_o("jump_lookup", 1, 32'h4000, 0, 0, 0);
        issue(32'h1104, BEQ, 32'h1104, 5, 6, 1, 32'h4000, 32'h4000, 0);
        expect_o("jump_nt", 1, 32'h4000, 1, 1, 32'h110C);
        idle(32'h1104);                 expect_o("jump_cnt10", 1, 32'h4000, 0, 0, 0);
        issue(32'h1104, JUMP, 32'h1104, 0, 0, 1, 32'h4000, 0, 32'h4100);
        expect_o("jump_tgt", 1, 32'h4000, 1, 1, 32'h4100);
        idle(32'h1104);                 expect_o("jump_retgt", 1, 32'h4100, 0, 0, 0);

        // Branch condition table, predicted not taken.
        foreach (vecs[i]) begin
            issue(32'h7000, vecs[i].kind, 32'h8014, vecs[i].rs, vecs[i].rt, 0, 0, 32'h8100, 0);
            expect_o($sformatf("cond%0d", i), 0, 0, vecs[i].taken ? 2'd1 : 2'd0, 1,
                     vecs[i].taken ? 32'h8100 : 32'h801C);
        end

        // Asynchronous reset mid-run clears the table.
        @(posedge clk); #1;
        resetn = 1'b0; if_pc = 32'h1104; exception_happen = 1'b1;
        expect_o("reset_mid", 0, 0, 0, 1, 0, 1, 0, 0);
        @(negedge clk); #1;
        resetn = 1'b1; exception_happen = 1'b0;
        idle(32'h1104);                 expect_o("post_reset", 0, 0, 0, 0, 0, 1, 0, 0);

        // Ten resolved branches, the first three mispredicted.
        for (int i = 0; i < 10; i++) begin
            issue(32'h7000, BEQ, 32'h9000, 5, 5, (i >= 3), (i >= 3) ? 32'h9040 : 32'h0, 32'h9040, 0);
            expect_o($sformatf("stat%0d", i), 0, 0, (i < 3) ? 2'd1 : 2'd0, 1, 32'h9040,
                     1, i, (i < 3) ? i : 3);
        end
        idle(32'h7000);                 expect_o("stat_total", 0, 0, 0, 0, 0, 1, 10, 3);
`ifdef BRANCH_STATS_EN
        @(negedge clk); #1;
        dut.r_stat_branches = 32'hFFFF_FFFF;
        issue(32'h7000, BEQ, 32'h9000, 5, 5, 1, 32'h9040, 32'h9040, 0);
        expect_o("stat_pre", 0, 0, 0, 1, 32'h9040, 1, 32'hFFFF_FFFF, 3);
        idle(32'h7000);                 expect_o("stat_wrap", 0, 0, 0, 0, 0, 1, 0, 3);
`endif

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk); #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
